mem_tile_resp: RTL

MEM_TILE_RESP -- requirements
Module: mem_tile_resp

---
 rtl/mem_tile_resp.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_tile_resp.sv
// Tile responder for the opm/OK protocol. One 128-bit tile request is accepted
// at a time. The tile is moved to or from a 64-bit backing SRAM as two
// half-tile beats, after an optional start-up delay of LAT cycles.
module mem_tile_resp #(
  parameter int ADDR_BITS = 14,
  parameter int LAT       = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          memAddr,
  input  logic [4:0]           memOpm,
  input  logic [127:0]         memDataIn,
  output logic [127:0]         memDataOut,
  output logic [1:0]           memOK,
  output logic [ADDR_BITS:0]   sramAddr,
  output logic                 sramWe,
  output logic [63:0]          sramWdata,
  input  logic [63:0]          sramRdata
);

  localparam logic [4:0] UMEM_OPM_READY   = 5'b00000;
  localparam logic [4:0] UMEM_OPM_RD_TILE = 5'b01001;
  localparam logic [4:0] UMEM_OPM_WR_TILE = 5'b01010;

  localparam logic [1:0] UMEM_OK_READY = 2'd0;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'd1;
  localparam logic [1:0] UMEM_OK_OK    = 2'd2;
  localparam logic [1:0] UMEM_OK_FAULT = 2'd3;

  typedef enum logic [2:0] {IDLE, WAIT, B0, B1, CAP, DONE} stateType;
  typedef enum logic [1:0] {KIND_RD, KIND_WR, KIND_FAULT} kindType;

  stateType               state, stateNext;
  kindType                kind, kindNext;
  logic [3:0]             cnt, cntNext;
  logic [ADDR_BITS-1:0]   ix, ixNext;
  logic [127:0]           data, dataNext;
  logic [1:0]             okNext;
  logic [127:0]           dataOutNext;

  // Byte-offset bits and aliased upper address bits are ignored.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{memAddr[31:ADDR_BITS+4], memAddr[3:0]};

  // Next-state, next-register and backing-memory strobe decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned and infers a latch.
    stateNext   = state;
    kindNext    = kind;
    cntNext     = cnt;
    ixNext      = ix;
    dataNext    = data;
    okNext      = memOK;
    dataOutNext = memDataOut;
    sramAddr    = {ix, 1'b0};
    sramWe      = 1'b0;
    sramWdata   = data[63:0];

    case (state)
      IDLE: begin
        if (memOpm != UMEM_OPM_READY) begin
          ixNext   = memAddr[ADDR_BITS+3:4];
          dataNext = memDataIn;
          okNext   = UMEM_OK_HOLD;
          if (memOpm == UMEM_OPM_RD_TILE) begin
            kindNext = KIND_RD;
          end else if (memOpm == UMEM_OPM_WR_TILE) begin
            kindNext = KIND_WR;
          end else begin
            kindNext = KIND_FAULT;
          end
          // Non-tile opcodes skip the backing memory entirely. They spend
          // their single HOLD cycle in CAP, which only finishes the response.
          if ((memOpm != UMEM_OPM_RD_TILE) && (memOpm != UMEM_OPM_WR_TILE)) begin
            stateNext = CAP;
          end else if (LAT > 0) begin
            stateNext = WAIT;
            cntNext   = 4'(LAT - 1);
          end else begin
            stateNext = B0;
          end
        end
      end

      WAIT: begin
        if (cnt == 4'd0) begin
          stateNext = B0;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end

      B0: begin
        sramAddr = {ix, 1'b0};
        if (kind == KIND_WR) begin
          sramWe    = 1'b1;
          sramWdata = data[63:0];
        end
        stateNext = B1;
      end

      B1: begin
        sramAddr = {ix, 1'b1};
        if (kind == KIND_WR) begin
          sramWe    = 1'b1;
          sramWdata = data[127:64];
          okNext    = UMEM_OK_OK;
          stateNext = DONE;
        end else begin
          // The low half arrives now, one cycle after the B0 address.
          dataNext[63:0] = sramRdata;
          stateNext      = CAP;
        end
      end

      CAP: begin
        stateNext = DONE;
        if (kind == KIND_RD) begin
          dataOutNext = {sramRdata, data[63:0]};
          okNext      = UMEM_OK_OK;
        end else begin
          okNext = UMEM_OK_FAULT;
        end
      end

      DONE: begin
        if (memOpm == UMEM_OPM_READY) begin
          okNext    = UMEM_OK_READY;
          stateNext = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
        okNext    = UMEM_OK_READY;
      end
    endcase
  end

  // State, latched request and registered response outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      kind       <= KIND_RD;
      cnt        <= 4'd0;
      ix         <= '0;
      data       <= '0;
      memOK      <= UMEM_OK_READY;
      memDataOut <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before this edge, regardless of statement order.
      state      <= stateNext;
      kind       <= kindNext;
      cnt        <= cntNext;
      ix         <= ixNext;
      data       <= dataNext;
      memOK      <= okNext;
      memDataOut <= dataOutNext;
    end
  end

endmodule
